spi_master: RTL and testbench

Single-byte SPI mode-0 master that drives the SPI slave stage's `sclk_in`, `mosi_in` and `ss_in` inputs and collects the slave's `miso` reply. It accepts one byte per start request and shifts it out MSB-first on MOSI. It captures eight MISO bits LSB-first, matching the slave's transmit order. Frames are paced slowly enough for the slave's two-cycle input delay and edge detection to resolve every SCLK edge.

---
 rtl/spi_master.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: single-byte SPI mode-0 master, MOSI shifted MSB-first, MISO captured LSB-first.
// Optional macro SPI_MASTER_STUTTER_EN adds a stall input (stutter_in) and its registered echo (st).
module spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
`ifdef SPI_MASTER_STUTTER_EN
  input  logic       stutter_in,
  output logic       st,
`endif
  input  logic       miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [3:0]       r_bit_cnt;
  logic [6:0]       r_tx_shift;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_rx_data;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_ss;
  logic             r_done;

  state_t           w_state_next;
  logic [DIV_W-1:0] w_div_next;
  logic [GAP_W-1:0] w_gap_next;
  logic [3:0]       w_bit_next;
  logic [6:0]       w_tx_next;
  logic [7:0]       w_rx_next;
  logic [7:0]       w_rx_data_next;
  logic             w_sclk_next;
  logic             w_mosi_next;
  logic             w_ss_next;
  logic             w_done_next;
  logic             w_div_last;
  logic [2:0]       w_bit_idx;
  logic             w_stall;

`ifdef SPI_MASTER_STUTTER_EN
  logic r_st;

  assign w_stall = stutter_in;
  assign st      = r_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= 1'b0;
    end else begin
      r_st <= stutter_in;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  assign w_div_last = (r_div_cnt == DIV_LAST);
  // During the k-th LOW phase the bit count already equals k, so k-1 wraps 8 onto index 7.
  assign w_bit_idx  = r_bit_cnt[2:0] - 3'd1;

  always_comb begin
    w_state_next   = r_state;
    w_div_next     = r_div_cnt;
    w_gap_next     = r_gap_cnt;
    w_bit_next     = r_bit_cnt;
    w_tx_next      = r_tx_shift;
    w_rx_next      = r_rx_shift;
    w_rx_data_next = r_rx_data;
    w_sclk_next    = r_sclk;
    w_mosi_next    = r_mosi;
    w_ss_next      = r_ss;
    w_done_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_LEAD;
          w_div_next   = '0;
          w_bit_next   = '0;
          w_tx_next    = tx_data[6:0];
          w_rx_next    = '0;
          w_ss_next    = 1'b0;
          w_sclk_next  = 1'b0;
          w_mosi_next  = tx_data[7];
        end
      end
      S_LEAD: begin
        if (w_div_last) begin
          w_state_next = S_HIGH;
          w_div_next   = '0;
          w_sclk_next  = 1'b1;
        end else begin
          w_div_next = r_div_cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_state_next = S_LOW;
          w_div_next   = '0;
          w_sclk_next  = 1'b0;
          w_bit_next   = r_bit_cnt + 4'd1;
          // Zeros shift in behind the data, so the eighth falling edge leaves MOSI low.
          w_mosi_next  = r_tx_shift[6];
          w_tx_next    = {r_tx_shift[5:0], 1'b0};
        end else begin
          w_div_next = r_div_cnt + 1'b1;
        end
      end
      S_LOW: begin
        if (w_div_last) begin
          w_rx_next[w_bit_idx] = miso;
          w_div_next           = '0;
          if (r_bit_cnt == 4'd8) begin
            w_state_next   = S_GAP;
            w_gap_next     = '0;
            w_bit_next     = '0;
            w_ss_next      = 1'b1;
            w_done_next    = 1'b1;
            w_rx_data_next = w_rx_next;
          end else begin
            w_state_next = S_HIGH;
            w_sclk_next  = 1'b1;
          end
        end else begin
          w_div_next = r_div_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_next = S_IDLE;
          w_gap_next   = '0;
        end else begin
          w_gap_next = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss       <= 1'b1;
      r_done     <= 1'b0;
    end else if (!w_stall) begin
      r_state    <= w_state_next;
      r_div_cnt  <= w_div_next;
      r_gap_cnt  <= w_gap_next;
      r_bit_cnt  <= w_bit_next;
      r_tx_shift <= w_tx_next;
      r_rx_shift <= w_rx_next;
      r_rx_data  <= w_rx_data_next;
      r_sclk     <= w_sclk_next;
      r_mosi     <= w_mosi_next;
      r_ss       <= w_ss_next;
      r_done     <= w_done_next;
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign ss      = r_ss;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: frame-level model of the SPI master checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int D  = 4;
  localparam int G  = 2;
  localparam int L  = 17 * D;
  localparam int D6 = 6;
  localparam int G6 = 3;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso = 1'b0;
  logic       stutter_in = 1'b0;
  logic       ready, done, sclk, mosi, ss;
  logic [7:0] rx_data;

  logic       start6 = 1'b0;
  logic [7:0] tx6 = 8'h96;
  logic       miso6 = 1'b0;
  logic       ready6, done6, sclk6, mosi6, ss6;
  logic [7:0] rx6;

`ifdef SPI_MASTER_STUTTER_EN
  logic       st;
  logic       stutter6 = 1'b0;
  logic       st6;
`endif

  spi_master #(.CLK_DIV(D), .GAP_CYCLES(G)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .ready(ready), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .ss(ss),
`ifdef SPI_MASTER_STUTTER_EN
    .stutter_in(stutter_in), .st(st),
`endif
    .miso(miso)
  );

  spi_master #(.CLK_DIV(D6), .GAP_CYCLES(G6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .tx_data(tx6),
    .ready(ready6), .done(done6), .rx_data(rx6),
    .sclk(sclk6), .mosi(mosi6), .ss(ss6),
`ifdef SPI_MASTER_STUTTER_EN
    .stutter_in(stutter6), .st(st6),
`endif
    .miso(miso6)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Frame model: m_c counts non-stalled cycles since the accept cycle.
  logic [7:0] reply = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_active = 1'b0;
  int         m_c = 0;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_rx = 8'h00;
  logic       m_st = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_c      = 0;
      m_rx     = 8'h00;
      m_st     = 1'b0;
    end else begin
      m_st = stutter_in;
      if (!stutter_in) begin
        if (m_active) begin
          m_c++;
          if (m_c == L + 1) m_rx = reply;
          if (m_c == L + 1 + G) begin
            m_active = 1'b0;
            m_c      = 0;
          end
        end else if (start) begin
          m_active = 1'b1;
          m_c      = 1;
          m_tx     = tx_data;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit   inf;
    int   p;
    int   f;
    logic e_sclk;
    logic e_mosi;
    if (m_valid) begin
      inf    = m_active && (m_c >= 1) && (m_c <= L);
      p      = inf ? (m_c - 1) / D : 0;
      f      = p / 2;
      e_sclk = inf && (p % 2 == 1);
      e_mosi = 1'b0;
      if (inf && f < 8) e_mosi = m_tx[7-f];
      check("ss", ss, !inf);
      check("sclk", sclk, e_sclk);
      check("mosi", mosi, e_mosi);
      check("done", done, m_active && (m_c == L + 1));
      check("ready", ready, !m_active);
      check("rx_data", rx_data, m_rx);
`ifdef SPI_MASTER_STUTTER_EN
      check("st", st, m_st);
`endif
    end
  end

  // Slave stand-in: after the k-th SCLK falling edge it presents reply[k-1].
  int   fall_cnt = 0;
  logic sl_sclk = 1'b0;
  always @(negedge clk) begin
    if (ss !== 1'b0) fall_cnt = 0;
    else if (sclk === 1'b0 && sl_sclk === 1'b1) fall_cnt++;
    sl_sclk = sclk;
    miso = 1'b0;
    if (fall_cnt >= 1 && fall_cnt <= 8) miso = reply[fall_cnt-1];
  end

  int         rise_cnt = 0;
  int         ss_low = 0;
  int         done_cnt = 0;
  int         done_at = -1;
  int         ready_at = -1;
  logic [7:0] mosi_cap = 8'h00;
  logic       mon_sclk = 1'b0;
  logic       mon_ready = 1'b1;
  always @(negedge clk) begin
    if (sclk === 1'b1 && mon_sclk === 1'b0) begin
      mosi_cap = {mosi_cap[6:0], mosi};
      rise_cnt++;
    end
    if (ss === 1'b0) ss_low++;
    if (done === 1'b1) begin
      done_cnt++;
      done_at = cyc;
    end
    if (ready === 1'b1 && mon_ready === 1'b0) ready_at = cyc;
    mon_sclk  = sclk;
    mon_ready = ready;
  end

  int d6_cnt = 0;
  int d6_at[4];
  always @(negedge clk) begin
    if (done6 === 1'b1) begin
      if (d6_cnt < 4) d6_at[d6_cnt] = cyc;
      d6_cnt++;
    end
  end

  int t_acc = 0;
  int s0, r0, d0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] t, input logic [7:0] r);
    s0      = ss_low;
    r0      = rise_cnt;
    d0      = done_cnt;
    reply   = r;
    tx_data = t;
    start   = 1'b1;
    t_acc   = cyc;
    tick(1);
    start   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d6_at[i] = 0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_ss", ss, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_rx", rx_data, 8'h00);
    tick(2);

    // start asserted together with rst must not open a frame
    rst = 1'b1; start = 1'b1;
    tick(1);
    rst = 1'b0; start = 1'b0;
    tick(3);
    check("start_in_rst_ss", ss, 1'b1);

    // reset in cycle 30 of a frame
    launch(8'hFF, 8'hFF);
    tick(29);
    rst = 1'b1; start = 1'b1;
    tick(1);
    rst = 1'b0; start = 1'b0;
    check("midrst_ss", ss, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_ready", ready, 1'b1);
    tick(80);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_rx", rx_data, 8'h00);

    // baseline frame: 0xA5 out, 0x3C back
    launch(8'hA5, 8'h3C);
    tick(79);
    check("a5_done_cycle", done_at - t_acc, 69);
    check("a5_ready_cycle", ready_at - t_acc, 71);
    check("a5_ss_low", ss_low - s0, 68);
    check("a5_rises", rise_cnt - r0, 8);
    check("a5_mosi_bits", mosi_cap, 8'b1010_0101);
    check("a5_rx", rx_data, 8'h3C);
    check("a5_done_cnt", done_cnt - d0, 1);

    // extra start pulses in cycles 10 and 40 are ignored
    launch(8'h5A, 8'h81);
    tick(9);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(29);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(40);
    check("busy_done_cnt", done_cnt - d0, 1);
    check("busy_done_cycle", done_at - t_acc, 69);
    check("busy_rx", rx_data, 8'h81);
    check("busy_mosi_bits", mosi_cap, 8'h5A);

`ifdef SPI_MASTER_STUTTER_EN
    launch(8'hA5, 8'h3C);
    for (int rc = 1; rc <= 85; rc++) begin
      stutter_in = (rc == 15) || (rc == 22) || (rc == 33) || (rc == 47) || (rc == 60);
      tick(1);
    end
    stutter_in = 1'b0;
    check("stut_done_cycle", done_at - t_acc, 74);
    check("stut_rx", rx_data, 8'h3C);
    check("stut_mosi_bits", mosi_cap, 8'hA5);
    check("stut_done_cnt", done_cnt - d0, 1);
`endif

    // CLK_DIV=6, GAP_CYCLES=3 with start held high
    start6 = 1'b1;
    tick(330);
    start6 = 1'b0;
    check("d6_frames", d6_cnt >= 3, 1'b1);
    check("d6_period_a", d6_at[1] - d6_at[0], 106);
    check("d6_period_b", d6_at[2] - d6_at[1], 106);
    check("d6_first", d6_at[0] > 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
